// File: rtl/snowbro2_snd_sched.sv
// Sound-CPU write scheduler: CPU writes are queued in order and replayed to the
// YM2151 / OKI6295 with a fixed strobe shape and per-chip recovery gaps.
module snowbro2_snd_sched #(
    parameter int AW      = 3,
    parameter int WR_LEN  = 4,
    parameter int YM_GAP  = 64,
    parameter int OKI_GAP = 8
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       YM2151_CEN,
    input  logic       OKI_CEN,
    input  logic       cmd_we,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] cmd_din,
    input  logic       flush,
    output logic       cmd_full,
    output logic       cmd_idle,
    output logic       cmd_drop,
    output logic       YM2151_CS,
    output logic       YM2151_WE,
    output logic       YM2151_WR_CMD,
    output logic [7:0] YM2151_DIN,
    output logic       OKI_WE,
    output logic [7:0] OKI_DIN,
    output logic       OKI_BANK
);
    localparam int          DEPTH    = 1 << AW;
    localparam int          YGW      = $clog2(YM_GAP + 1);
    localparam int          OGW      = $clog2(OKI_GAP + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
    state_t state, state_nx;

    logic [9:0]     mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    count;
    logic [9:0]     head;
    logic           push, pop, launch_ym, launch_oki, bank_wr, gap_load;
    logic [3:0]     wcnt;
    logic           tgt_ym;
    logic [YGW-1:0] ym_gap;
    logic [OGW-1:0] oki_gap;

    assign head     = mem[rp];
    assign cmd_full = (count == FULL_CNT);
    assign cmd_idle = (count == '0) && (state == IDLE);
    assign push     = cmd_we && !cmd_full;

    always_ff @(posedge CLK96) begin
        if (push) mem[wp] <= {cmd_sel, cmd_din};
    end

    // A rejected push still reports a drop when a pop frees a slot that same cycle.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            cmd_drop <= 1'b0;
        end else begin
            cmd_drop <= cmd_we && cmd_full;
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            ym_gap  <= '0;
            oki_gap <= '0;
        end else begin
            if (gap_load && tgt_ym && YM2151_WR_CMD) ym_gap <= YGW'(YM_GAP);
            else if (YM2151_CEN && ym_gap != '0)     ym_gap <= ym_gap - 1'b1;
            if (gap_load && !tgt_ym)                 oki_gap <= OGW'(OKI_GAP);
            else if (OKI_CEN && oki_gap != '0)       oki_gap <= oki_gap - 1'b1;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            tgt_ym        <= 1'b0;
            YM2151_WR_CMD <= 1'b0;
            YM2151_DIN    <= '0;
            OKI_DIN       <= '0;
            OKI_BANK      <= 1'b0;
            wcnt          <= '0;
        end else begin
            if (launch_ym) begin
                tgt_ym        <= 1'b1;
                YM2151_WR_CMD <= head[8];
                YM2151_DIN    <= head[7:0];
            end
            if (launch_oki) begin
                tgt_ym  <= 1'b0;
                OKI_DIN <= head[7:0];
            end
            if (bank_wr) OKI_BANK <= head[0];
            wcnt <= (state == STROBE) ? wcnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch_ym || launch_oki) state_nx = SETUP;
            SETUP:   state_nx = STROBE;
            STROBE:  if (gap_load) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The head entry blocks while its chip is recovering; nothing behind it may bypass.
    always_comb begin
        pop        = 1'b0;
        launch_ym  = 1'b0;
        launch_oki = 1'b0;
        bank_wr    = 1'b0;
        if (state == IDLE && count != '0) begin
            case (head[9:8])
                2'd3: begin
                    pop     = 1'b1;
                    bank_wr = 1'b1;
                end
                2'd2: if (oki_gap == '0) begin
                    pop        = 1'b1;
                    launch_oki = 1'b1;
                end
                default: if (ym_gap == '0) begin
                    pop       = 1'b1;
                    launch_ym = 1'b1;
                end
            endcase
        end
        gap_load  = (state == STROBE) && (wcnt == 4'(WR_LEN - 1));
        YM2151_CS = tgt_ym && (state != IDLE);
        YM2151_WE = !(tgt_ym && state == STROBE);
        OKI_WE    = !(!tgt_ym && state == STROBE);
    end
endmodule

// File: tb/tb_snowbro2_snd_sched.sv
// Randomized bench for snowbro2_snd_sched: a queue model of the command stream
// checks replay order, strobe shape, recovery gaps, bank ordering, flush and reset.
module tb_snowbro2_snd_sched;
    localparam int AW = 3, WR_LEN = 4, YM_GAP = 64, OKI_GAP = 8, DEPTH = 8;

    logic       CLK96 = 1'b0, RESET96 = 1'b1, YM2151_CEN = 1'b0, OKI_CEN = 1'b0;
    logic       cmd_we = 1'b0, flush = 1'b0;
    logic [1:0] cmd_sel = '0;
    logic [7:0] cmd_din = '0;
    logic       cmd_full, cmd_idle, cmd_drop, YM2151_CS, YM2151_WE, YM2151_WR_CMD;
    logic       OKI_WE, OKI_BANK;
    logic [7:0] YM2151_DIN, OKI_DIN;

    snowbro2_snd_sched #(.AW(AW), .WR_LEN(WR_LEN), .YM_GAP(YM_GAP), .OKI_GAP(OKI_GAP)) dut (
        .CLK96(CLK96), .RESET96(RESET96), .YM2151_CEN(YM2151_CEN), .OKI_CEN(OKI_CEN),
        .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_din(cmd_din), .flush(flush),
        .cmd_full(cmd_full), .cmd_idle(cmd_idle), .cmd_drop(cmd_drop),
        .YM2151_CS(YM2151_CS), .YM2151_WE(YM2151_WE), .YM2151_WR_CMD(YM2151_WR_CMD),
        .YM2151_DIN(YM2151_DIN), .OKI_WE(OKI_WE), .OKI_DIN(OKI_DIN), .OKI_BANK(OKI_BANK)
    );

    always #5 CLK96 = ~CLK96;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] din;
    } ent_t;

    ent_t mq[$];
    logic model_bank = 1'b0;
    int   n_checks = 0, n_fail = 0;
    int   cen_mode = 0;
    int   ym_ticks = 0, oki_ticks = 0, ym_rel = 0, oki_rel = 0;
    bit   ym_gv = 0, oki_gv = 0;
    int   ym_last_diff = 0, oki_last_diff = 0, ym_writes = 0, oki_writes = 0;
    int   ym_len = 0, oki_len = 0;
    logic prev_ym_we = 1'b1, prev_oki_we = 1'b1, last_ym_data = 1'b0;

    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge CLK96); #1;
            k++;
            case (cen_mode)
                1: begin
                    YM2151_CEN = (k % 24 == 0);
                    OKI_CEN    = 1'($urandom_range(0, 1));
                end
                2: begin
                    YM2151_CEN = 1'b1;
                    OKI_CEN    = 1'b1;
                end
                default: begin
                    YM2151_CEN = 1'($urandom_range(0, 1));
                    OKI_CEN    = 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    always @(posedge CLK96) begin
        if (YM2151_CEN) ym_ticks++;
        if (OKI_CEN)    oki_ticks++;
    end

    // Observed chip writes are matched against the model stream; bank entries
    // ahead of a write must already be applied when that write starts.
    always @(negedge CLK96) begin
        ent_t e;
        if (RESET96) begin
            prev_ym_we = 1'b1; prev_oki_we = 1'b1;
            ym_len = 0; oki_len = 0; ym_gv = 0; oki_gv = 0;
        end else begin
            if (!YM2151_WE && prev_ym_we) begin
                ym_writes++;
                while (mq.size() > 0 && mq[0].sel == 2'd3) begin
                    model_bank = mq[0].din[0];
                    void'(mq.pop_front());
                end
                n_checks++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ym_unexpected_write: got a0=%0d din=%h, required no write", YM2151_WR_CMD, YM2151_DIN);
                end else begin
                    e = mq.pop_front();
                    if ({e.sel, e.din} !== {1'b0, YM2151_WR_CMD, YM2151_DIN} || YM2151_CS !== 1'b1) begin
                        n_fail++;
                        $display("FAIL ym_write: got a0=%0d din=%h cs=%b, required sel=%0d din=%h cs=1",
                                 YM2151_WR_CMD, YM2151_DIN, YM2151_CS, e.sel, e.din);
                    end
                end
                if (ym_gv) begin
                    ym_last_diff = ym_ticks - ym_rel;
                    n_checks++;
                    if (ym_last_diff < YM_GAP) begin
                        n_fail++;
                        $display("FAIL ym_gap: got %0d CEN ticks, required >= %0d", ym_last_diff, YM_GAP);
                    end
                end
                last_ym_data = YM2151_WR_CMD;
                ym_len = 1;
            end else if (!YM2151_WE) begin
                ym_len++;
            end else if (!prev_ym_we) begin
                n_checks++;
                if (ym_len != WR_LEN || YM2151_CS !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ym_strobe: got len=%0d release_cs=%b, required len=%0d cs=1", ym_len, YM2151_CS, WR_LEN);
                end
                if (last_ym_data) begin
                    ym_rel = ym_ticks;
                    ym_gv = 1;
                end
            end
            prev_ym_we = YM2151_WE;

            if (!OKI_WE && prev_oki_we) begin
                oki_writes++;
                while (mq.size() > 0 && mq[0].sel == 2'd3) begin
                    model_bank = mq[0].din[0];
                    void'(mq.pop_front());
                end
                n_checks++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL oki_unexpected_write: got din=%h, required no write", OKI_DIN);
                end else begin
                    e = mq.pop_front();
                    if (e.sel !== 2'd2 || e.din !== OKI_DIN || OKI_BANK !== model_bank || YM2151_CS !== 1'b0) begin
                        n_fail++;
                        $display("FAIL oki_write: got din=%h bank=%b ym_cs=%b, required sel=%0d din=%h bank=%b ym_cs=0",
                                 OKI_DIN, OKI_BANK, YM2151_CS, e.sel, e.din, model_bank);
                    end
                end
                if (oki_gv) begin
                    oki_last_diff = oki_ticks - oki_rel;
                    n_checks++;
                    if (oki_last_diff < OKI_GAP) begin
                        n_fail++;
                        $display("FAIL oki_gap: got %0d CEN ticks, required >= %0d", oki_last_diff, OKI_GAP);
                    end
                end
                oki_len = 1;
            end else if (!OKI_WE) begin
                oki_len++;
            end else if (!prev_oki_we) begin
                n_checks++;
                if (oki_len != WR_LEN) begin
                    n_fail++;
                    $display("FAIL oki_strobe: got len=%0d, required %0d", oki_len, WR_LEN);
                end
                oki_rel = oki_ticks;
                oki_gv = 1;
            end
            prev_oki_we = OKI_WE;
        end
    end

    task automatic push(input logic [1:0] sel, input logic [7:0] din, input bit to_model);
        if (to_model) mq.push_back('{sel, din});
        cmd_we = 1'b1; cmd_sel = sel; cmd_din = din;
        @(posedge CLK96); #1;
        cmd_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK96);
            if (cmd_idle === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge CLK96); #1;
    endtask

    task automatic settle_bank();
        while (mq.size() > 0 && mq[0].sel == 2'd3) begin
            model_bank = mq[0].din[0];
            void'(mq.pop_front());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK96);
        @(negedge CLK96);
        n_checks++;
        if ({YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN, OKI_WE, OKI_DIN, OKI_BANK, cmd_full, cmd_idle, cmd_drop}
            !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got cs=%b we=%b a0=%b ydin=%h owe=%b odin=%h bank=%b full=%b idle=%b drop=%b",
                     YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN, OKI_WE, OKI_DIN, OKI_BANK, cmd_full, cmd_idle, cmd_drop);
        end
        @(posedge CLK96); #1;
        RESET96 = 1'b0;
        @(posedge CLK96); #1;
    endtask

    task automatic test_basic();
        logic exp_cs, exp_we, exp_idle;
        push(2'd0, 8'h28, 1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge CLK96);
            exp_cs   = (c >= 2 && c <= 3 + WR_LEN);
            exp_we   = !(c >= 3 && c <= 2 + WR_LEN);
            exp_idle = (c >= 4 + WR_LEN);
            n_checks++;
            if ({YM2151_CS, YM2151_WE, cmd_idle} !== {exp_cs, exp_we, exp_idle} ||
                (exp_cs && (YM2151_WR_CMD !== 1'b0 || YM2151_DIN !== 8'h28))) begin
                n_fail++;
                $display("FAIL basic_timing c%0d: got cs=%b we=%b idle=%b a0=%b din=%h, required cs=%b we=%b idle=%b a0=0 din=28",
                         c, YM2151_CS, YM2151_WE, cmd_idle, YM2151_WR_CMD, YM2151_DIN, exp_cs, exp_we, exp_idle);
            end
        end
        @(posedge CLK96); #1;
    endtask

    task automatic test_ym_gap();
        int w0;
        bit ok;
        cen_mode = 1;
        w0 = ym_writes;
        push(2'd0, 8'h08, 1);
        push(2'd1, 8'h78, 1);
        push(2'd1, 8'h79, 1);
        wait_idle(5000, ok);
        n_checks++;
        if (!ok || ym_writes - w0 != 3) begin
            n_fail++;
            $display("FAIL ym_gap_drain: got idle=%0d writes=%0d, required idle=1 writes=3", ok, ym_writes - w0);
        end
        n_checks++;
        if (ym_last_diff > YM_GAP + 2) begin
            n_fail++;
            $display("FAIL ym_gap_late: got %0d ticks, required <= %0d", ym_last_diff, YM_GAP + 2);
        end
        cen_mode = 2;
        repeat (80) @(posedge CLK96);
        #1;
    endtask

    task automatic test_oki();
        int w0;
        bit ok;
        cen_mode = 0;
        w0 = oki_writes;
        push(2'd2, 8'h80, 1);
        push(2'd3, 8'h01, 1);
        push(2'd2, 8'h10, 1);
        wait_idle(1000, ok);
        settle_bank();
        n_checks++;
        if (!ok || oki_writes - w0 != 2 || OKI_BANK !== model_bank || OKI_DIN !== 8'h10) begin
            n_fail++;
            $display("FAIL oki_seq: got idle=%0d writes=%0d bank=%b din=%h, required idle=1 writes=2 bank=%b din=10",
                     ok, oki_writes - w0, OKI_BANK, OKI_DIN, model_bank);
        end
        n_checks++;
        if (oki_last_diff > OKI_GAP + 2) begin
            n_fail++;
            $display("FAIL oki_gap_late: got %0d ticks, required <= %0d", oki_last_diff, OKI_GAP + 2);
        end
    endtask

    task automatic test_bank_latency();
        logic old;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            settle_bank();
            old = model_bank;
            d = 8'($urandom) ^ {7'd0, ~old};
            push(2'd3, d, 1);
            @(negedge CLK96);
            n_checks++;
            if (OKI_BANK !== old) begin
                n_fail++;
                $display("FAIL bank_early: got %b, required %b", OKI_BANK, old);
            end
            @(negedge CLK96);
            n_checks++;
            if (OKI_BANK !== d[0]) begin
                n_fail++;
                $display("FAIL bank_latency: got %b, required %b", OKI_BANK, d[0]);
            end
            @(posedge CLK96); #1;
        end
        settle_bank();
    endtask

    task automatic test_back_to_back();
        int w0;
        bit ok;
        cen_mode = 1;
        w0 = ym_writes;
        push(2'd1, 8'($urandom), 1);
        for (int i = 0; i < DEPTH; i++) push({1'b0, 1'($urandom)}, 8'($urandom), 1);
        n_checks++;
        if (cmd_full !== 1'b1 || cmd_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full: got full=%b drop=%b, required full=1 drop=0", cmd_full, cmd_drop);
        end
        push(2'd0, 8'hEE, 0);
        n_checks++;
        if (cmd_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pulse: got %b, required 1", cmd_drop);
        end
        @(posedge CLK96); #1;
        n_checks++;
        if (cmd_drop !== 1'b0 || cmd_full !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_once: got drop=%b full=%b, required drop=0 full=1", cmd_drop, cmd_full);
        end
        cen_mode = 2;
        wait_idle(3000, ok);
        n_checks++;
        if (!ok || mq.size() != 0 || ym_writes - w0 != DEPTH + 1) begin
            n_fail++;
            $display("FAIL fill_drain: got idle=%0d left=%0d writes=%0d, required idle=1 left=0 writes=%0d",
                     ok, mq.size(), ym_writes - w0, DEPTH + 1);
        end
        repeat (80) @(posedge CLK96);
        #1;
    endtask

    task automatic test_flush();
        int w0;
        logic exp_we, exp_idle;
        cen_mode = 2;
        w0 = ym_writes;
        push(2'd0, 8'hA1, 1);
        push(2'd0, 8'hA2, 1);
        push(2'd0, 8'hA3, 1);
        push(2'd0, 8'hA4, 1);
        flush = 1'b1;
        mq.delete();
        @(posedge CLK96); #1;
        flush = 1'b0;
        for (int c = 5; c <= 4 + WR_LEN; c++) begin
            @(negedge CLK96);
            exp_we   = !(c <= 2 + WR_LEN);
            exp_idle = (c >= 4 + WR_LEN);
            n_checks++;
            if (YM2151_WE !== exp_we || cmd_idle !== exp_idle) begin
                n_fail++;
                $display("FAIL flush_timing c%0d: got we=%b idle=%b, required we=%b idle=%b", c, YM2151_WE, cmd_idle, exp_we, exp_idle);
            end
        end
        repeat (30) @(posedge CLK96);
        #1;
        n_checks++;
        if (ym_writes - w0 != 1 || cmd_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_discard: got writes=%0d idle=%b, required writes=1 idle=1", ym_writes - w0, cmd_idle);
        end
    endtask

    task automatic test_async_reset();
        int w0;
        cen_mode = 2;
        push(2'd3, 8'h01, 1);
        push(2'd0, 8'h55, 1);
        push(2'd1, 8'h66, 1);
        push(2'd0, 8'h77, 1);
        n_checks++;
        if (YM2151_WE !== 1'b0 || OKI_BANK !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got we=%b bank=%b, required we=0 bank=1", YM2151_WE, OKI_BANK);
        end
        w0 = ym_writes;
        #2 RESET96 = 1'b1;
        #1;
        n_checks++;
        if ({YM2151_WE, YM2151_CS, OKI_BANK, cmd_idle, cmd_full} !== 5'b10010) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b cs=%b bank=%b idle=%b full=%b, required we=1 cs=0 bank=0 idle=1 full=0",
                     YM2151_WE, YM2151_CS, OKI_BANK, cmd_idle, cmd_full);
        end
        mq.delete();
        model_bank = 1'b0;
        @(posedge CLK96); #1;
        RESET96 = 1'b0;
        repeat (20) @(posedge CLK96);
        #1;
        n_checks++;
        if (ym_writes != w0 || cmd_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got writes=%0d idle=%b, required writes=0 idle=1", ym_writes - w0, cmd_idle);
        end
    endtask

    task automatic test_random();
        bit ok;
        cen_mode = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                push(2'($urandom_range(0, 3)), 8'($urandom), 1);
                repeat ($urandom_range(0, 3)) @(posedge CLK96);
                #1;
            end
            wait_idle(4000, ok);
            settle_bank();
            n_checks++;
            if (!ok || mq.size() != 0 || OKI_BANK !== model_bank) begin
                n_fail++;
                $display("FAIL random_round%0d: got idle=%0d left=%0d bank=%b, required idle=1 left=0 bank=%b",
                         r, ok, mq.size(), OKI_BANK, model_bank);
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, required summary before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ym_gap();
        test_oki();
        test_bank_latency();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
